// File: rtl/input_cond_pkg.sv
// Shared defaults, counter sizing helper and channel vector type for the
// input conditioner.
package input_cond_pkg;

  localparam int DEF_WIDTH        = 5;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CNT = 16;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [DEF_WIDTH-1:0] chan_vec_t;

endpackage

// File: rtl/debounce_chan.sv
// One input channel: synchroniser chain, debounce counter, clean level and
// change pulse. Optional RISE/FALL split under INPUT_COND_EDGE_SPLIT_EN.
module debounce_chan
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter logic RESET_BIT    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic changed
`ifdef INPUT_COND_EDGE_SPLIT_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam int CW = cnt_w(DEBOUNCE_CNT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_BIT}};
      clean   <= RESET_BIT;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
      changed <= 1'b0;
      // Any return to the current clean level discards a partial count.
      if (sync == clean) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        clean   <= sync;
        cnt     <= '0;
        changed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef INPUT_COND_EDGE_SPLIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= (sync != clean) && (cnt == LAST) && sync;
      fall <= (sync != clean) && (cnt == LAST) && !sync;
    end
  end
`endif

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces WIDTH raw lines, with change pulses and a
// post-reset VALID flag. Optional RISE/FALL ports: INPUT_COND_EDGE_SPLIT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int               DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] RAW_IN,
  output logic [WIDTH-1:0] CLEAN_OUT,
  output logic [WIDTH-1:0] CHANGED,
  output logic             VALID
`ifdef INPUT_COND_EDGE_SPLIT_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CNT;
  localparam int SW     = cnt_w(SETTLE);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic [SW-1:0] settle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .RESET_BIT   (RESET_VAL[i])
    ) u_chan (
      .clk    (CLK),
      .rst_n  (RST_N),
      .raw    (RAW_IN[i]),
      .clean  (CLEAN_OUT[i]),
      .changed(CHANGED[i])
`ifdef INPUT_COND_EDGE_SPLIT_EN
      ,
      .rise   (RISE[i]),
      .fall   (FALL[i])
`endif
    );
  end

  // VALID is set on the same edge the settle count reaches its limit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle <= '0;
      VALID  <= 1'b0;
    end else begin
      if (settle != SETTLE_MAX) settle <= settle + 1'b1;
      if (settle == SETTLE_LAST) VALID <= 1'b1;
    end
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that feeds the gate-logic/output-register stage.
- Takes five raw, asynchronous digital lines (switches or external pins) and delivers clean, glitch-free values on CLEAN_OUT. CLEAN_OUT[0] drives IN1, up to CLEAN_OUT[4] driving IN5.
- Each channel has its own synchroniser and debounce counter.
- Also produces per-channel one-cycle change pulses and a post-reset VALID flag.

Parameters:
- WIDTH, 5: number of input channels.
- SYNC_STAGES, 2: flip-flops in each synchroniser chain; must be >= 2.
- DEBOUNCE_CNT, 16: consecutive cycles a new level must hold before it is accepted; must be >= 1.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into CLEAN_OUT at reset.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- RAW_IN  input  WIDTH  raw asynchronous inputs.
- CLEAN_OUT  output  WIDTH  debounced, synchronised levels; registered.
- CHANGED  output  WIDTH  one-cycle pulse on the cycle CLEAN_OUT[i] updates; registered.
- VALID  output  1  high once the settle period after reset has elapsed; registered.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_N is asynchronous and active-low.
- While RST_N=0:
  - all synchroniser flops = RESET_VAL bits
  - CLEAN_OUT = RESET_VAL
  - per-channel counters = 0
  - CHANGED = 0
  - VALID = 0
  - settle counter = 0
- Release of RST_N: the design relies on a synchronised deassertion. The block itself adds no reset synchroniser.
- Synchroniser: RAW_IN[i] passes through SYNC_STAGES flops. SYNC[i] is the last stage.
- Per-channel counter cnt[i] is $clog2(DEBOUNCE_CNT+1) bits wide. Each cycle, in priority order:
  - SYNC[i]==CLEAN_OUT[i]: cnt[i]<=0, CHANGED[i]<=0 (glitch rejection; any partial count is discarded).
  - Otherwise, if cnt[i]==DEBOUNCE_CNT-1: CLEAN_OUT[i]<=SYNC[i], cnt[i]<=0, CHANGED[i]<=1.
  - Otherwise: cnt[i]<=cnt[i]+1, CHANGED[i]<=0.
- Latency:
  - Count RAW_IN first being sampled at edge 1.
  - CLEAN_OUT updates at edge SYNC_STAGES+DEBOUNCE_CNT, which is edge 18 with defaults.
  - CHANGED pulses in the same cycle CLEAN_OUT takes its new value.
- DEBOUNCE_CNT=1 disables filtering. CLEAN_OUT then follows SYNC with one cycle of delay.
- A pulse shorter than DEBOUNCE_CNT cycles at SYNC is fully rejected: no CHANGED, no CLEAN_OUT change.
- A new transition that starts in the same cycle as an acceptance starts a fresh count from 0 on the next cycle.
- Channels are fully independent. Several CHANGED bits may pulse in the same cycle.
- Settle counter:
  - Counts cycles after reset release, saturating at SYNC_STAGES+DEBOUNCE_CNT.
  - VALID<=1 when the count reaches that value and stays 1 until the next reset.
  - CHANGED pulses before VALID are still generated.
- Reset asserted mid-count aborts all counts immediately, with outputs set to their reset values asynchronously.
- No combinational path from RAW_IN to any output.

Optional Feature:
- Macro: INPUT_COND_EDGE_SPLIT_EN.
- When defined:
  - Adds output ports RISE [WIDTH-1:0] and FALL [WIDTH-1:0], both registered.
  - RISE[i] pulses for one cycle when CLEAN_OUT[i] goes 0->1; FALL[i] pulses when it goes 1->0.
  - RISE|FALL == CHANGED at all times.
  - Both ports reset to 0.
- When undefined: the ports do not exist and only CHANGED is provided. The logic is otherwise identical.

Decomposition:
- Package input_cond_pkg holds:
  - default constants (WIDTH=5, SYNC_STAGES=2, DEBOUNCE_CNT=16)
  - a counter-width function, cnt_w(n) = $clog2(n+1)
  - a typedef for the channel vector
- Sub-module debounce_chan: one channel's synchroniser, counter, CLEAN bit, CHANGED bit and optional RISE/FALL. It is instantiated WIDTH times in a generate loop.
- The settle counter and VALID live in the top module.

Test Plan:
- Reset hold:
  - Stimulus: RST_N=0 with RAW_IN=5'b11111 toggling.
  - Required: CLEAN_OUT=00000, CHANGED=0, VALID=0 throughout. Drop RST_N mid-run and check outputs clear asynchronously without waiting for a CLK edge.
- Basic latency:
  - Stimulus: defaults; RAW_IN[0] steps 0->1, first sampled at edge 1, held high.
  - Required: CLEAN_OUT[0]=1 and CHANGED[0]=1 at edge 18 only; CHANGED[0]=0 at edge 19.
- Glitch rejection:
  - Stimulus: RAW_IN[2] high for 15 cycles, low for 1, high for 16.
  - Required: exactly one CHANGED[2] pulse, occurring 16+2 cycles after the second rising edge is sampled. No pulse for the first high burst.
- Simultaneous channels:
  - Stimulus: RAW_IN steps 00000->10101 in one cycle.
  - Required: CHANGED=10101 in one cycle and CLEAN_OUT=10101. With INPUT_COND_EDGE_SPLIT_EN defined: RISE=10101, FALL=00000.
- VALID timing:
  - Stimulus: release reset, RAW_IN static.
  - Required: VALID rises at cycle 18 after release and stays 1. Re-assert RST_N and check VALID=0 immediately.
- No filtering:
  - Stimulus: DEBOUNCE_CNT=1, square wave on RAW_IN[4] with period 4.
  - Required: CLEAN_OUT[4] reproduces the wave delayed by 3 cycles, with a CHANGED[4] pulse on every transition.
